// File: rtl/mem_shuffler_v1.sv
// Load shuffler: gathers NrLane memory beats into one block and reorders it into lane-interleaved VRF layout.
// Optional 2-entry output skid buffer enabled by defining MEM_SHUFFLER_SKID_EN.
package mem_shuffler_v1_pkg;
  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;
endpackage

module mem_shuffler_v1
  import mem_shuffler_v1_pkg::*;
#(
  parameter int unsigned NrLane        = 4,
  parameter int unsigned VRFWordWidthB = 8,
  parameter int unsigned ByteBlock     = NrLane * VRFWordWidthB
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      in_valid_i,
  output logic                                      in_ready_o,
  input  logic [8*VRFWordWidthB-1:0]                data_i,
  input  logic                                      is_first_i,
  input  logic [$clog2(VRFWordWidthB)-1:0]          skip_first_i,
  input  logic                                      is_last_i,
  input  logic [$clog2(VRFWordWidthB)-1:0]          skip_last_i,
  input  vew_e                                      sew_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [NrLane-1:0][8*VRFWordWidthB-1:0]    data_o,
  output logic [NrLane-1:0][VRFWordWidthB-1:0]      strb_o
);

  localparam int unsigned W     = VRFWordWidthB;
  localparam int unsigned SlotW = (NrLane > 1) ? $clog2(NrLane) : 1;

  logic [SlotW-1:0]       slot_q;
  vew_e                   sew_q;
  vew_e                   sew_eff;
  logic [ByteBlock*8-1:0] buf_data_q;
  logic [ByteBlock-1:0]   buf_strb_q;
  logic [W-1:0]           beat_mask;
  logic                   in_fire;
  logic                   block_close;
  logic [ByteBlock*8-1:0] blk_data;
  logic [ByteBlock-1:0]   blk_strb;
  logic [ByteBlock*8-1:0] shuf_data;
  logic [ByteBlock-1:0]   shuf_strb;

  // Destination byte for block byte b at element width 2^k bytes; ByteBlock
  // flags an element wider than a VRF word, which has no valid placement.
  function automatic int unsigned dest_byte(input int unsigned b, input int unsigned k);
    int unsigned esz;
    int unsigned e;
    int unsigned lane;
    int unsigned off;
    esz  = 32'd1 << k;
    e    = b / esz;
    lane = e % NrLane;
    off  = (e / NrLane) * esz + (b % esz);
    if (off < W) return lane * W + off;
    else         return ByteBlock;
  endfunction

  assign in_fire     = in_valid_i && in_ready_o;
  assign block_close = in_fire && ((slot_q == SlotW'(NrLane - 1)) || is_last_i);
  assign sew_eff     = (slot_q == '0) ? sew_i : sew_q;

  always_comb begin
    beat_mask = '1;
    for (int unsigned i = 0; i < W; i++) begin
      if (is_first_i && (i < 32'(skip_first_i)))    beat_mask[i] = 1'b0;
      if (is_last_i && (i >= W - 32'(skip_last_i))) beat_mask[i] = 1'b0;
    end
  end

  // Current block as it would look with the incoming beat merged in.
  always_comb begin
    blk_data = buf_data_q;
    blk_strb = buf_strb_q;
    for (int unsigned s = 0; s < NrLane; s++) begin
      if (slot_q == SlotW'(s)) begin
        blk_data[s*8*W +: 8*W] = data_i;
        blk_strb[s*W +: W]     = beat_mask;
      end
    end
  end

  always_comb begin
    shuf_data = '0;
    shuf_strb = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (32'(sew_eff) == k) begin
        for (int unsigned b = 0; b < ByteBlock; b++) begin
          if (dest_byte(b, k) < ByteBlock) begin
            shuf_data[dest_byte(b, k)*8 +: 8] = blk_data[b*8 +: 8];
            shuf_strb[dest_byte(b, k)]        = blk_strb[b];
          end
        end
      end
    end
  end

  // Buffer is cleared on close so unfilled slots of a short block read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q     <= '0;
      sew_q      <= EW8;
      buf_data_q <= '0;
      buf_strb_q <= '0;
    end else if (in_fire) begin
      if (slot_q == '0) sew_q <= sew_i;
      if (block_close) begin
        slot_q     <= '0;
        buf_data_q <= '0;
        buf_strb_q <= '0;
      end else begin
        slot_q     <= slot_q + SlotW'(1);
        buf_data_q <= blk_data;
        buf_strb_q <= blk_strb;
      end
    end
  end

`ifdef MEM_SHUFFLER_SKID_EN
  logic                   head_valid_q;
  logic [ByteBlock*8-1:0] head_data_q;
  logic [ByteBlock-1:0]   head_strb_q;
  logic                   tail_valid_q;
  logic [ByteBlock*8-1:0] tail_data_q;
  logic [ByteBlock-1:0]   tail_strb_q;
  logic                   deq;

  assign deq        = head_valid_q && out_ready_i;
  assign in_ready_o = !(head_valid_q && tail_valid_q);

  // Enqueue only happens while not full, so the tail is empty whenever a
  // dequeue and enqueue coincide and the new block can go straight to head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_strb_q  <= '0;
      tail_valid_q <= 1'b0;
      tail_data_q  <= '0;
      tail_strb_q  <= '0;
    end else if (deq && block_close) begin
      head_valid_q <= 1'b1;
      head_data_q  <= shuf_data;
      head_strb_q  <= shuf_strb;
    end else if (deq) begin
      head_valid_q <= tail_valid_q;
      if (tail_valid_q) begin
        head_data_q <= tail_data_q;
        head_strb_q <= tail_strb_q;
      end
      tail_valid_q <= 1'b0;
    end else if (block_close) begin
      if (!head_valid_q) begin
        head_valid_q <= 1'b1;
        head_data_q  <= shuf_data;
        head_strb_q  <= shuf_strb;
      end else begin
        tail_valid_q <= 1'b1;
        tail_data_q  <= shuf_data;
        tail_strb_q  <= shuf_strb;
      end
    end
  end

  assign out_valid_o = head_valid_q;
  assign data_o      = head_data_q;
  assign strb_o      = head_strb_q;
`else
  logic                   out_valid_q;
  logic [ByteBlock*8-1:0] out_data_q;
  logic [ByteBlock-1:0]   out_strb_q;

  assign in_ready_o = !out_valid_q || out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else if (block_close) begin
      out_valid_q <= 1'b1;
      out_data_q  <= shuf_data;
      out_strb_q  <= shuf_strb;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign data_o      = out_data_q;
  assign strb_o      = out_strb_q;
`endif

endmodule
